// File: rtl/spi_sd_responder.sv
// Minimal SPI-mode SD card stand-in: oversamples the master's SPI pins, frames
// 6-byte commands, decodes a small command subset and answers with R1 after an Ncr gap.
module spi_sd_responder #(
  parameter int NCR_BYTES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  input  logic        cs_n,
  output logic        cmd_v,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  output logic        idle_o
);

  typedef enum logic [1:0] {HUNT, CMD, NCR, RESP} state_t;

  localparam logic [3:0] NCR_LAST = (NCR_BYTES > 0) ? 4'(NCR_BYTES - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [2:0]  sclk_sy;
  logic [1:0]  mosi_sy, cs_sy;
  logic [6:0]  rx;
  logic [2:0]  bit_cnt;
  logic [3:0]  byte_cnt;
  logic [7:0]  tx, r1;
  logic [5:0]  idx_buf;
  logic [31:0] arg_buf;
  logic        idle, app;

  logic        rise, fall, cs_hi, byte_done, cmd_done;
  logic [7:0]  rx_byte, out_byte, r1_nxt;
  logic        idle_nxt, app_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sy <= 3'b000;
      mosi_sy <= 2'b11;
      cs_sy   <= 2'b11;
    end else begin
      sclk_sy <= {sclk_sy[1:0], sclk};
      mosi_sy <= {mosi_sy[0], mosi};
      cs_sy   <= {cs_sy[0], cs_n};
    end
  end

  assign rise      = sclk_sy[1] & ~sclk_sy[2];
  assign fall      = ~sclk_sy[1] & sclk_sy[2];
  assign cs_hi     = cs_sy[1];
  assign rx_byte   = {rx, mosi_sy[1]};
  assign byte_done = rise & (bit_cnt == 3'd7) & ~cs_hi;
  assign cmd_done  = byte_done & (state == CMD) & (byte_cnt == 4'd5);
  assign out_byte  = (state == RESP) ? r1 : 8'hFF;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= HUNT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (byte_done) begin
      case (state)
        HUNT: if (rx_byte[7:6] == 2'b01) state_nxt = CMD;
        CMD:  if (byte_cnt == 4'd5) state_nxt = (NCR_BYTES == 0) ? RESP : NCR;
        NCR:  if (byte_cnt == NCR_LAST) state_nxt = RESP;
        RESP: state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
    if (cs_hi) state_nxt = HUNT;
  end

  // R1 decode on the final (CRC/stop) byte; a bad stop bit leaves idle/app untouched
  always_comb begin
    idle_nxt = idle;
    app_nxt  = app;
    r1_nxt   = 8'h04 | {7'b0, idle};
    if (!rx_byte[0]) begin
      r1_nxt = 8'h08 | {7'b0, idle};
    end else begin
      app_nxt = 1'b0;
      case (idx_buf)
        6'd0: begin
          idle_nxt = 1'b1;
          r1_nxt   = 8'h01;
        end
        6'd55: begin
          app_nxt = 1'b1;
          r1_nxt  = {7'b0, idle};
        end
        6'd41: begin
          if (app) begin
            idle_nxt = 1'b0;
            r1_nxt   = 8'h00;
          end
        end
        6'd8, 6'd58: r1_nxt = {7'b0, idle};
        default: r1_nxt = 8'h04 | {7'b0, idle};
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx       <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx       <= 8'hFF;
      miso     <= 1'b1;
      idx_buf  <= '0;
      arg_buf  <= '0;
      r1       <= 8'hFF;
      idle     <= 1'b1;
      app      <= 1'b0;
      cmd_v    <= 1'b0;
      cmd_idx  <= '0;
      cmd_arg  <= '0;
    end else begin
      cmd_v <= cmd_done;
      if (cmd_done) begin
        cmd_idx <= idx_buf;
        cmd_arg <= arg_buf;
        idle    <= idle_nxt;
        app     <= app_nxt;
        r1      <= r1_nxt;
      end
      if (cs_hi) begin
        rx       <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        tx       <= 8'hFF;
        miso     <= 1'b1;
      end else begin
        if (rise) begin
          rx      <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            HUNT: if (rx_byte[7:6] == 2'b01) begin
              idx_buf  <= rx_byte[5:0];
              byte_cnt <= 4'd1;
            end
            CMD: begin
              if (byte_cnt == 4'd5) byte_cnt <= 4'd0;
              else begin
                arg_buf  <= {arg_buf[23:0], rx_byte};
                byte_cnt <= byte_cnt + 4'd1;
              end
            end
            NCR:     byte_cnt <= byte_cnt + 4'd1;
            default: byte_cnt <= 4'd0;
          endcase
        end
        // bit_cnt==0 on a fall means the preceding rise closed a byte: load the next one
        if (fall) begin
          if (bit_cnt == 3'd0) begin
            tx   <= out_byte;
            miso <= out_byte[7];
          end else begin
            tx   <= {tx[6:0], 1'b1};
            miso <= tx[6];
          end
        end
      end
    end
  end

  assign idle_o = idle;

endmodule

// File: tb/tb_spi_sd_responder.sv
// Scoreboarded bench for spi_sd_responder: stimulus queues expected miso bytes and
// command captures, independent monitors pop and compare as the DUT produces them.
module tb_spi_sd_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b1;
  logic        cs_n = 1'b1;
  logic        miso, cmd_v, idle_o;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;

  spi_sd_responder #(.NCR_BYTES(1)) dut (
    .clock(clock), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .miso(miso),
    .cs_n(cs_n), .cmd_v(cmd_v), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .idle_o(idle_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        idle;
  } cmd_t;

  cmd_t       exp_cmd[$];
  logic [7:0] exp_miso[$];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // master samples miso on sclk rise; reassemble bytes and compare
  logic [7:0] msh = 8'h00;
  int         mbits = 0;
  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) mbits = 0;
    else begin
      msh = {msh[6:0], miso};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        if (exp_miso.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL miso_byte: got %02h with no byte expected", msh);
        end else check("miso_byte", {32'h0, msh}, {32'h0, exp_miso.pop_front()});
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && cmd_v) begin
      if (exp_cmd.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL cmd_v: got unexpected pulse idx=%0d", cmd_idx);
      end else begin
        cmd_t c;
        c = exp_cmd.pop_front();
        check("cmd_idx", {34'h0, cmd_idx}, {34'h0, c.idx});
        check("cmd_arg", {8'h0, cmd_arg}, {8'h0, c.arg});
        check("idle_o", {39'h0, idle_o}, {39'h0, c.idle});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic half();
    repeat (6) @(negedge clock);
  endtask

  task automatic bits(input logic [7:0] d, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = d[i];
      half();
      sclk = 1'b1;
      half();
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] d, input logic [7:0] e);
    exp_miso.push_back(e);
    bits(d, 8);
  endtask

  task automatic send_cmd(input logic [47:0] f, input logic idle);
    cmd_t c;
    c.idx  = f[45:40];
    c.arg  = f[39:8];
    c.idle = idle;
    exp_cmd.push_back(c);
    for (int i = 5; i >= 0; i--) xfer(f[i*8 +: 8], 8'hFF);
  endtask

  // full command: 6 bytes, one Ncr filler, R1, one trailing idle byte
  task automatic frame(input logic [47:0] f, input logic [7:0] r1, input logic idle);
    send_cmd(f, idle);
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, r1);
    xfer(8'hFF, 8'hFF);
  endtask

  initial begin
    repeat (5) @(negedge clock);
    check("rst_miso", {39'h0, miso}, 40'h1);
    check("rst_cmd_v", {39'h0, cmd_v}, 40'h0);
    check("rst_cmd_idx", {34'h0, cmd_idx}, 40'h0);
    check("rst_cmd_arg", {8'h0, cmd_arg}, 40'h0);
    check("rst_idle", {39'h0, idle_o}, 40'h1);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    cs_n = 1'b0;
    repeat (10) @(negedge clock);

    for (int i = 0; i < 4; i++) xfer(8'hFF, 8'hFF);

    frame(48'h40_00_00_00_00_95, 8'h01, 1'b1);
    frame(48'h48_00_00_01_AA_87, 8'h01, 1'b1);
    frame(48'h77_00_00_00_00_65, 8'h01, 1'b1);
    frame(48'h69_40_00_00_00_77, 8'h00, 1'b0);
    check("idle_after_acmd41", {39'h0, idle_o}, 40'h0);
    frame(48'h40_00_00_00_00_95, 8'h01, 1'b1);
    frame(48'h69_40_00_00_00_77, 8'h05, 1'b1);
    frame(48'h51_00_00_00_00_00, 8'h09, 1'b1);

    // abort mid-frame with cs_n, then a clean CMD0
    xfer(8'h40, 8'hFF);
    xfer(8'h00, 8'hFF);
    xfer(8'h00, 8'hFF);
    cs_n = 1'b1;
    repeat (10) @(negedge clock);
    cs_n = 1'b0;
    repeat (10) @(negedge clock);
    frame(48'h40_00_00_00_00_95, 8'h01, 1'b1);

    // drop idle, then reset in the middle of CMD8's R1
    frame(48'h77_00_00_00_00_65, 8'h01, 1'b1);
    frame(48'h69_40_00_00_00_77, 8'h00, 1'b0);
    send_cmd(48'h48_00_00_01_AA_87, 1'b0);
    xfer(8'hFF, 8'hFF);
    bits(8'hFF, 3);
    repeat (6) @(negedge clock);
    check("miso_pre_reset", {39'h0, miso}, 40'h0);
    reset_n = 1'b0;
    #1;
    check("miso_in_reset", {39'h0, miso}, 40'h1);
    check("idx_in_reset", {34'h0, cmd_idx}, 40'h0);
    check("arg_in_reset", {8'h0, cmd_arg}, 40'h0);
    check("idle_in_reset", {39'h0, idle_o}, 40'h1);
    cs_n = 1'b1;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    cs_n = 1'b0;
    repeat (10) @(negedge clock);
    frame(48'h40_00_00_00_00_95, 8'h01, 1'b1);

    repeat (50) @(negedge clock);
    check("miso_queue_drained", 40'(exp_miso.size()), 40'h0);
    check("cmd_queue_drained", 40'(exp_cmd.size()), 40'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
